// File: rtl/conv_operand_feeder.sv
// conv_operand_feeder
// Transmit side of the accumulator-adder operand interface. Products from the
// multiplier array are buffered in a FIFO; on request one convolution window of
// WIN_LEN operands is issued back-to-back on IEEE_FORMAT/en, followed by a
// single-cycle win_done pulse for the controller.
module conv_operand_feeder #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned WIN_LEN = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      start,
    output logic [DATA_W-1:0]         IEEE_FORMAT,
    output logic                      en,
    output logic                      win_done,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] WIN_CNT  = CW'(WIN_LEN);
    localparam logic [CW-1:0] REM_INIT = CW'(WIN_LEN - 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_STREAM
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    // Window sequencer state and registered outputs
    state_t            r_state;
    logic [CW-1:0]     r_rem;
    logic [DATA_W-1:0] r_data;
    logic              r_en;
    logic              r_done;

    // Combinational next values
    state_t            w_state_nxt;
    logic [CW-1:0]     w_rem_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_en_nxt;
    logic              w_done_nxt;
    logic              w_pop;
    logic              w_push;
    logic              w_not_full;
    logic [DATA_W-1:0] w_head;

    assign w_not_full = (r_count != FULL_CNT);
    assign w_push     = in_valid & w_not_full;
    assign w_head     = r_mem[r_rd_ptr];

    assign in_ready    = w_not_full;
    assign count       = r_count;
    assign busy        = (r_state != S_IDLE);
    assign IEEE_FORMAT = r_data;
    assign en          = r_en;
    assign win_done    = r_done;

    // FIFO data write; storage needs no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // FIFO pointers wrap modulo DEPTH; occupancy tracks push/pop on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sequencer state register and registered operand outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_data  <= '0;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_data  <= w_data_nxt;
            r_en    <= w_en_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state and output decode: ARM holds until the whole window is buffered,
    // so the STREAM pops that follow can never underflow the FIFO
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_data_nxt  = r_data;
        w_en_nxt    = 1'b0;
        w_done_nxt  = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                if (r_count >= WIN_CNT) begin
                    w_pop       = 1'b1;
                    w_data_nxt  = w_head;
                    w_en_nxt    = 1'b1;
                    w_rem_nxt   = REM_INIT;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (r_rem != '0) begin
                    w_pop      = 1'b1;
                    w_data_nxt = w_head;
                    w_en_nxt   = 1'b1;
                    w_rem_nxt  = r_rem - CW'(1);
                end else begin
                    w_data_nxt  = '0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A pop must always find a buffered operand
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) w_pop |-> (r_count != '0));

    // Occupancy never exceeds the FIFO size
    a_count_bound: assert property (@(posedge clk) disable iff (rst) r_count <= FULL_CNT);

endmodule

// File: tb/tb_conv_operand_feeder.sv
// Testbench for conv_operand_feeder: scoreboard of expected operands in push
// order, checked by a monitor whenever en is high, plus per-scenario checks.
module tb_conv_operand_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        start;
    logic [31:0] ieee;
    logic        en;
    logic        win_done;
    logic        busy;
    logic [4:0]  count;

    logic [31:0] d1_in_data;
    logic        d1_in_valid;
    logic        d1_in_ready;
    logic        d1_start;
    logic [31:0] d1_ieee;
    logic        d1_en;
    logic        d1_done;
    logic        d1_busy;
    logic [4:0]  d1_count;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] q[$];
    logic [31:0] q1[$];

    always #5 clk = ~clk;

    conv_operand_feeder #(.DATA_W(32), .DEPTH(16), .WIN_LEN(9)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .start(start), .IEEE_FORMAT(ieee), .en(en), .win_done(win_done), .busy(busy), .count(count)
    );

    conv_operand_feeder #(.DATA_W(32), .DEPTH(16), .WIN_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(d1_in_data), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .start(d1_start), .IEEE_FORMAT(d1_ieee), .en(d1_en), .win_done(d1_done), .busy(d1_busy),
        .count(d1_count)
    );

    // Scoreboard monitor: every en-high cycle must carry the oldest accepted word
    always @(negedge clk) begin
        logic [31:0] exp_w;
        if (!rst && en) begin
            n_checks++;
            if (q.size() == 0) begin
                $display("FAIL stream_data: got %08h with en high, required no operand (scoreboard empty)", ieee);
            end else begin
                exp_w = q.pop_front();
                if (ieee !== exp_w) $display("FAIL stream_data: got %08h expected %08h", ieee, exp_w);
                else n_pass++;
            end
        end
    end

    task automatic push_seq(input logic [31:0] base, input int n, input int n_acc, input logic [31:0] step);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = base + step * 32'(i);
            if (i < n_acc) q.push_back(base + step * 32'(i));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Measures one window from the current negedge until win_done (bounded)
    task automatic observe_window(output int n_en, output int first_at, output bit gap,
                                  output bit done_ok, output bit timeout);
        bit prev_en;
        bit dropped;
        n_en = 0; first_at = -1; gap = 0; done_ok = 0; timeout = 1;
        prev_en = en; dropped = 0;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (en) begin
                if (n_en == 0) first_at = t;
                if (dropped) gap = 1;
                n_en++;
            end else if (n_en > 0) begin
                dropped = 1;
            end
            if (win_done) begin
                done_ok = prev_en && !en;
                timeout = 0;
                break;
            end
            prev_en = en;
        end
    endtask

    task automatic test_nominal();
        logic [31:0] fv [9];
        int n_en, first_at;
        bit gap, done_ok, timeout;
        fv = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
               32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = fv[i];
            q.push_back(fv[i]);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (count !== 5'd9) $display("FAIL nom_count_pre: got %0d expected 9", count); else n_pass++;
        pulse_start();
        n_checks++; if (busy !== 1'b1) $display("FAIL nom_busy: got %0b expected 1", busy); else n_pass++;
        n_checks++; if (en !== 1'b0) $display("FAIL nom_en_arm: got %0b expected 0", en); else n_pass++;
        observe_window(n_en, first_at, gap, done_ok, timeout);
        n_checks++; if (timeout) $display("FAIL nom_timeout: got timeout expected win_done"); else n_pass++;
        n_checks++; if (first_at != 1) $display("FAIL nom_latency: got %0d expected 1", first_at); else n_pass++;
        n_checks++; if (n_en != 9) $display("FAIL nom_en_len: got %0d expected 9", n_en); else n_pass++;
        n_checks++; if (gap) $display("FAIL nom_gap: got gap expected contiguous en"); else n_pass++;
        n_checks++; if (!done_ok) $display("FAIL nom_done_timing: got misplaced win_done expected cycle after last en"); else n_pass++;
        n_checks++; if (count !== 5'd0) $display("FAIL nom_count_post: got %0d expected 0", count); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL nom_idle: got busy %0b expected 0", busy); else n_pass++;
        n_checks++; if (q.size() != 0) $display("FAIL nom_drained: got %0d left expected 0", q.size()); else n_pass++;
        @(negedge clk);
        n_checks++; if (win_done !== 1'b0) $display("FAIL nom_done_pulse: got %0b expected 0", win_done); else n_pass++;
    endtask

    task automatic test_reset();
        push_seq(32'hC0DE0000, 3, 3, 32'd1);
        pulse_start();
        n_checks++; if (busy !== 1'b1) $display("FAIL rst_busy_pre: got %0b expected 1", busy); else n_pass++;
        n_checks++; if (count !== 5'd3) $display("FAIL rst_count_pre: got %0d expected 3", count); else n_pass++;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (en !== 1'b0) $display("FAIL rst_en: got %0b expected 0", en); else n_pass++;
        n_checks++; if (ieee !== 32'h0) $display("FAIL rst_data: got %08h expected 00000000", ieee); else n_pass++;
        n_checks++; if (win_done !== 1'b0) $display("FAIL rst_done: got %0b expected 0", win_done); else n_pass++;
        n_checks++; if (count !== 5'd0) $display("FAIL rst_count: got %0d expected 0", count); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_ready: got %0b expected 1", in_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b expected 0", busy); else n_pass++;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_early_start();
        int n_en, first_at;
        bit gap, done_ok, timeout;
        push_seq(32'h10000000, 4, 4, 32'h10);
        pulse_start();
        n_checks++; if (busy !== 1'b1) $display("FAIL early_busy: got %0b expected 1", busy); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (en !== 1'b0) $display("FAIL early_en_wait: got %0b expected 0", en); else n_pass++;
        n_checks++; if (count !== 5'd4) $display("FAIL early_count: got %0d expected 4", count); else n_pass++;
        push_seq(32'h10000040, 5, 5, 32'h10);
        n_checks++; if (count !== 5'd9) $display("FAIL early_count9: got %0d expected 9", count); else n_pass++;
        n_checks++; if (en !== 1'b0) $display("FAIL early_en_edge: got %0b expected 0", en); else n_pass++;
        observe_window(n_en, first_at, gap, done_ok, timeout);
        n_checks++; if (timeout) $display("FAIL early_timeout: got timeout expected win_done"); else n_pass++;
        n_checks++; if (first_at != 1) $display("FAIL early_latency: got %0d expected 1", first_at); else n_pass++;
        n_checks++; if (n_en != 9) $display("FAIL early_en_len: got %0d expected 9", n_en); else n_pass++;
        n_checks++; if (gap || !done_ok) $display("FAIL early_shape: got gap=%0b done_ok=%0b expected 0/1", gap, done_ok); else n_pass++;
        n_checks++; if (q.size() != 0) $display("FAIL early_drained: got %0d left expected 0", q.size()); else n_pass++;
    endtask

    task automatic test_full();
        push_seq(32'hB0000000, 17, 16, 32'd1);
        n_checks++; if (count !== 5'd16) $display("FAIL full_count: got %0d expected 16", count); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL full_ready: got %0b expected 0", in_ready); else n_pass++;
        pulse_start();
        n_checks++; if (in_ready !== 1'b0) $display("FAIL full_ready_arm: got %0b expected 0", in_ready); else n_pass++;
        @(negedge clk);
        n_checks++; if (en !== 1'b1) $display("FAIL full_en_first: got %0b expected 1", en); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL full_ready_pop: got %0b expected 1", in_ready); else n_pass++;
        n_checks++; if (count !== 5'd15) $display("FAIL full_count_pop: got %0d expected 15", count); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hB1000000 + 32'(i);
            q.push_back(32'hB1000000 + 32'(i));
            @(negedge clk);
            n_checks++; if (count !== 5'd15) $display("FAIL full_concurrent_count: got %0d expected 15", count); else n_pass++;
            n_checks++; if (en !== 1'b1) $display("FAIL full_concurrent_en: got %0b expected 1", en); else n_pass++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (win_done !== 1'b1 || en !== 1'b0) $display("FAIL full_done: got done=%0b en=%0b expected 1/0", win_done, en); else n_pass++;
        n_checks++; if (count !== 5'd15) $display("FAIL full_count_end: got %0d expected 15", count); else n_pass++;
        n_checks++; if (q.size() != 15) $display("FAIL full_sb_left: got %0d expected 15", q.size()); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        int seen;
        seen = 0;
        pulse_start();
        for (int t = 0; t < 20 && seen < 4; t++) begin
            @(negedge clk);
            if (en) seen++;
        end
        n_checks++; if (seen != 4) $display("FAIL mid_en_seen: got %0d expected 4", seen); else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_checks++; if (en !== 1'b0) $display("FAIL mid_en: got %0b expected 0", en); else n_pass++;
        n_checks++; if (ieee !== 32'h0) $display("FAIL mid_data: got %08h expected 00000000", ieee); else n_pass++;
        n_checks++; if (count !== 5'd0) $display("FAIL mid_count: got %0d expected 0", count); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %0b expected 0", busy); else n_pass++;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        test_nominal();
    endtask

    task automatic test_ignored_start();
        int n_en, first_at;
        bit gap, done_ok, timeout;
        logic [31:0] exp_w;
        push_seq(32'hD0000000, 9, 9, 32'd1);
        pulse_start();
        fork
            begin
                observe_window(n_en, first_at, gap, done_ok, timeout);
            end
            begin
                repeat (9) begin
                    @(negedge clk);
                    start = 1'b1;
                end
                @(negedge clk);
                start = 1'b0;
            end
        join
        n_checks++; if (timeout) $display("FAIL ign_timeout: got timeout expected win_done"); else n_pass++;
        n_checks++; if (n_en != 9 || !done_ok) $display("FAIL ign_window: got n_en=%0d done_ok=%0b expected 9/1", n_en, done_ok); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL ign_busy: got %0b expected 0", busy); else n_pass++;
        n_checks++; if (en !== 1'b0) $display("FAIL ign_en: got %0b expected 0", en); else n_pass++;
        n_checks++; if (q.size() != 0) $display("FAIL ign_drained: got %0d left expected 0", q.size()); else n_pass++;

        @(negedge clk);
        d1_in_valid = 1'b1;
        d1_in_data  = 32'h3F800000;
        q1.push_back(32'h3F800000);
        @(negedge clk);
        d1_in_valid = 1'b0;
        n_checks++; if (d1_count !== 5'd1) $display("FAIL w1_count: got %0d expected 1", d1_count); else n_pass++;
        d1_start = 1'b1;
        @(negedge clk);
        d1_start = 1'b0;
        n_checks++; if (d1_busy !== 1'b1 || d1_en !== 1'b0) $display("FAIL w1_arm: got busy=%0b en=%0b expected 1/0", d1_busy, d1_en); else n_pass++;
        @(negedge clk);
        exp_w = q1.pop_front();
        n_checks++; if (d1_en !== 1'b1) $display("FAIL w1_en: got %0b expected 1", d1_en); else n_pass++;
        n_checks++; if (d1_ieee !== exp_w) $display("FAIL w1_data: got %08h expected %08h", d1_ieee, exp_w); else n_pass++;
        @(negedge clk);
        n_checks++; if (d1_en !== 1'b0 || d1_done !== 1'b1) $display("FAIL w1_done: got en=%0b done=%0b expected 0/1", d1_en, d1_done); else n_pass++;
        n_checks++; if (d1_count !== 5'd0) $display("FAIL w1_count_end: got %0d expected 0", d1_count); else n_pass++;
        @(negedge clk);
        n_checks++; if (d1_done !== 1'b0 || d1_busy !== 1'b0) $display("FAIL w1_idle: got done=%0b busy=%0b expected 0/0", d1_done, d1_busy); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; start = 1'b0;
        d1_in_valid = 1'b0; d1_in_data = '0; d1_start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_nominal();
        test_early_start();
        test_full();
        test_reset_midstream();
        test_ignored_start();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
